// File: rtl/camera_capture_core.sv
// DVP camera capture: input sync, pixel assembly, X/Y tagging, crop window, output FIFO.
// Optional define CAPTURE_DECIMATE_EN keeps only even X/Y pixels and reports coordinates >>1.
module camera_capture_core #(
  parameter int BYTES_PER_PIX = 2,
  parameter int X_W           = 10,
  parameter int Y_W           = 10,
  parameter int SAMPLE_EDGE   = 1,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                               CLOCK,
  input  logic                               RESET,
  input  logic                               CMOS_PCLK,
  input  logic                               CMOS_HREF,
  input  logic                               CMOS_VSYNC,
  input  logic [7:0]                         CMOS_DQ,
  input  logic                               iEn,
  input  logic [X_W-1:0]                     iXStart,
  input  logic [X_W-1:0]                     iXEnd,
  input  logic [Y_W-1:0]                     iYStart,
  input  logic [Y_W-1:0]                     iYEnd,
  input  logic                               iReady,
  output logic                               oValid,
  output logic [Y_W+X_W+8*BYTES_PER_PIX-1:0] oData,
  output logic                               oFrameStart,
  output logic                               oFrameDone,
  output logic [15:0]                        oFrameCnt,
  output logic                               oOverflow,
  output logic                               oBusy
);
  localparam int PW = 8*BYTES_PER_PIX;
  localparam int OW = Y_W+X_W+PW;
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_VS, S_ACTIVE, S_DONE} state_t;
  state_t state_q, state_d;

  // Stage 1/2 are the synchronizer, stage 3 only feeds edge detection.
  logic [2:0] pclk_q, href_q, vs_q;
  logic [7:0] dq1_q, dq2_q;

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      pclk_q <= '0;
      href_q <= '0;
      vs_q   <= '0;
      dq1_q  <= '0;
      dq2_q  <= '0;
    end else begin
      pclk_q <= {pclk_q[1:0], CMOS_PCLK};
      href_q <= {href_q[1:0], CMOS_HREF};
      vs_q   <= {vs_q[1:0], CMOS_VSYNC};
      dq1_q  <= CMOS_DQ;
      dq2_q  <= dq1_q;
    end
  end

  logic sample, href_fall, vs_rise, vs_fall, frame_start, shift_en;
  assign sample      = (SAMPLE_EDGE != 0) ? (pclk_q[1] & ~pclk_q[2]) : (~pclk_q[1] & pclk_q[2]);
  assign href_fall   = href_q[2] & ~href_q[1];
  assign vs_rise     = vs_q[1] & ~vs_q[2];
  assign vs_fall     = ~vs_q[1] & vs_q[2];
  assign frame_start = (state_q == S_WAIT_VS) & vs_fall;
  assign shift_en    = (state_q == S_ACTIVE) & ~href_fall & sample & href_q[1];

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    oBusy      = (state_q != S_IDLE);
    oFrameDone = 1'b0;
    case (state_q)
      S_IDLE:    if (iEn) state_d = S_WAIT_VS;
      S_WAIT_VS: if (vs_fall) state_d = S_ACTIVE;
      S_ACTIVE:  if (vs_rise) state_d = S_DONE;
      S_DONE: begin
        oFrameDone = 1'b1;
        state_d    = iEn ? S_WAIT_VS : S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  // Earlier bytes of the pixel under construction; the newest byte lands in the LSBs.
  logic [PW-1:0] sh_d;
  generate
    if (BYTES_PER_PIX == 1) begin : g_sh1
      assign sh_d = dq2_q;
    end else begin : g_shn
      logic [PW-9:0] sh_q;
      assign sh_d = {sh_q, dq2_q};
      always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET)        sh_q <= '0;
        else if (shift_en) sh_q <= sh_d[PW-9:0];
      end
    end
  endgenerate

  logic [X_W-1:0] x_q, xs_q, xe_q, a_x_q, b_x_q;
  logic [Y_W-1:0] y_q, ys_q, ye_q, a_y_q, b_y_q;
  logic [1:0]     nb_q;
  logic [PW-1:0]  a_pix_q, b_pix_q;
  logic [OW-1:0]  c_data_q, c_data_d;
  logic [3:1]     vld_pipe_q;
  logic           in_win, keep, fs_q;

  assign in_win = (a_x_q >= xs_q) && (a_x_q <= xe_q) && (a_y_q >= ys_q) && (a_y_q <= ye_q);

  always_comb begin
`ifdef CAPTURE_DECIMATE_EN
    keep     = ~b_x_q[0] & ~b_y_q[0];
    c_data_d = {1'b0, b_y_q[Y_W-1:1], 1'b0, b_x_q[X_W-1:1], b_pix_q};
`else
    keep     = 1'b1;
    c_data_d = {b_y_q, b_x_q, b_pix_q};
`endif
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      x_q <= '0; y_q <= '0; nb_q <= '0; fs_q <= 1'b0;
      xs_q <= '0; xe_q <= '0; ys_q <= '0; ye_q <= '0;
      a_x_q <= '0; a_y_q <= '0; a_pix_q <= '0;
      b_x_q <= '0; b_y_q <= '0; b_pix_q <= '0;
      c_data_q <= '0; vld_pipe_q <= '0;
    end else begin
      fs_q          <= frame_start;
      vld_pipe_q[1] <= 1'b0;
      if (frame_start) begin
        x_q <= '0; y_q <= '0; nb_q <= '0;
        xs_q <= iXStart; xe_q <= iXEnd; ys_q <= iYStart; ye_q <= iYEnd;
      end else if (state_q == S_ACTIVE) begin
        if (href_fall) begin
          // Empty lines do not advance Y; a trailing partial pixel is dropped.
          if ((x_q != '0) || (nb_q != '0)) y_q <= (&y_q) ? y_q : y_q + 1'b1;
          x_q  <= '0;
          nb_q <= '0;
        end else if (shift_en) begin
          if (nb_q == 2'(BYTES_PER_PIX-1)) begin
            nb_q          <= '0;
            x_q           <= (&x_q) ? x_q : x_q + 1'b1;
            vld_pipe_q[1] <= 1'b1;
            a_pix_q       <= sh_d;
            a_x_q         <= x_q;
            a_y_q         <= y_q;
          end else begin
            nb_q <= nb_q + 1'b1;
          end
        end
      end
      vld_pipe_q[2] <= vld_pipe_q[1] & in_win;
      b_x_q         <= a_x_q;
      b_y_q         <= a_y_q;
      b_pix_q       <= a_pix_q;
      vld_pipe_q[3] <= vld_pipe_q[2] & keep;
      c_data_q      <= c_data_d;
    end
  end

  assign oFrameStart = fs_q;

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET)                 oFrameCnt <= '0;
    else if (state_q == S_DONE) oFrameCnt <= oFrameCnt + 16'd1;
  end

  logic [OW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          push, pop, full, wr_en;

  assign push   = vld_pipe_q[3];
  assign oValid = (cnt_q != '0);
  assign oData  = mem_q[rd_q];
  assign pop    = oValid & iReady;
  assign full   = (cnt_q == (AW+1)'(FIFO_DEPTH));
  // A pop frees the slot in the same cycle, so a full FIFO can still accept.
  assign wr_en  = push & (~full | pop);

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q <= '0; rd_q <= '0; cnt_q <= '0; oOverflow <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wr_q] <= c_data_q;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      case ({wr_en, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (push & ~wr_en) oOverflow <= 1'b1;
    end
  end
endmodule
